// File: rtl/upsizing.sv
// Width-doubling AXI-Stream stage: packs pairs of W-bit beats into one 2W-bit word,
// emitting a half-filled word (tkeep=2'b10) when a packet ends on a high half.
module upsizing #(
    parameter int W = 32
) (
    input  logic           aclk,
    input  logic           rst,
    input  logic [W-1:0]   in_tdata,
    input  logic           in_tvalid,
    input  logic           in_tlast,
    output logic           in_tready,
    output logic [2*W-1:0] out_tdata,
    output logic [1:0]     out_tkeep,
    output logic           out_tlast,
    output logic           out_tvalid,
    input  logic           out_tready
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [2*W-1:0]   out_tdata_q, out_tdata_d;
    logic [1:0]       out_tkeep_q, out_tkeep_d;
    logic             out_tlast_q, out_tlast_d;
    logic             out_tvalid_q, out_tvalid_d;

    logic             hi_valid_s;
    logic             slot_free_s;
    logic             in_tready_s;
    logic             accept_s;

    assign hi_valid_s  = (state_q == HALF);
    assign slot_free_s = ~out_tvalid_q | out_tready;
    // A non-last high beat never touches the output register, so it can enter under backpressure.
    assign in_tready_s = slot_free_s | (~hi_valid_s & ~in_tlast);
    assign accept_s    = in_tvalid & in_tready_s;

    // Next-state and output-register load logic.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        out_tdata_d  = out_tdata_q;
        out_tkeep_d  = out_tkeep_q;
        out_tlast_d  = out_tlast_q;
        out_tvalid_d = out_tvalid_q;

        if (out_tvalid_q & out_tready) begin
            out_tvalid_d = 1'b0;
        end else begin
            out_tvalid_d = out_tvalid_q;
        end

        case (state_q)
            EMPTY: begin
                if (accept_s) begin
                    if (in_tlast) begin
                        out_tdata_d  = {in_tdata, {W{1'b0}}};
                        out_tkeep_d  = 2'b10;
                        out_tlast_d  = 1'b1;
                        out_tvalid_d = 1'b1;
                    end else begin
                        hi_d    = in_tdata;
                        state_d = HALF;
                    end
                end else begin
                    state_d = EMPTY;
                end
            end
            HALF: begin
                if (accept_s) begin
                    out_tdata_d  = {hi_q, in_tdata};
                    out_tkeep_d  = 2'b11;
                    out_tlast_d  = in_tlast;
                    out_tvalid_d = 1'b1;
                    state_d      = EMPTY;
                end else begin
                    state_d = HALF;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State, held half and output register.
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q      <= EMPTY;
            hi_q         <= {W{1'b0}};
            out_tdata_q  <= {(2*W){1'b0}};
            out_tkeep_q  <= 2'b00;
            out_tlast_q  <= 1'b0;
            out_tvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            out_tdata_q  <= out_tdata_d;
            out_tkeep_q  <= out_tkeep_d;
            out_tlast_q  <= out_tlast_d;
            out_tvalid_q <= out_tvalid_d;
        end
    end

    assign in_tready  = in_tready_s;
    assign out_tdata  = out_tdata_q;
    assign out_tkeep  = out_tkeep_q;
    assign out_tlast  = out_tlast_q;
    assign out_tvalid = out_tvalid_q;

endmodule
